// File: rtl/uart_rx_if.sv
// APB register bus bundle for the UART receiver.
// The master drives address, control and write data; the slave returns read data.
interface uart_rx_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: APB-slave UART receiver. Synchronizes rxd, deframes
// start/data/parity/stop using the transmitter's baud code (T = 16<<baud),
// and holds the received byte plus sticky error flags for CPU read.
// Optional build macro UART_RX_FIFO_EN replaces the single holding register
// with a 4-entry receive FIFO and reports its level in STATUS[7:5].
module uart_rx #(
  parameter int DSIZE       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic     pclk,
  input  logic     reset,
  uart_rx_if.slave apb,
  input  logic     rxd,
  output logic     rx_irq
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] REG_CONFIG    = 6'd0;
  localparam logic [5:0] REG_CONTROL   = 6'd1;
  localparam logic [5:0] REG_RX_BUFFER = 6'd2;
  localparam logic [5:0] REG_STATUS    = 6'd3;

  // Widths outside 5..8 fall back to a full 8-bit frame.
  function automatic logic [3:0] eff_width(input logic [3:0] w);
    return ((w < 4'd5) || (w > 4'd8)) ? 4'd8 : w;
  endfunction

  function automatic logic [11:0] bit_period(input logic [2:0] baud);
    return 12'd16 << baud;
  endfunction

  // Bits enter at the MSB, so a short frame sits at the top of the shifter.
  function automatic logic [DSIZE-1:0] align_lsb(input logic [DSIZE-1:0] sh,
                                                 input logic [3:0] w);
    return sh >> (DSIZE - int'(w));
  endfunction

  function automatic logic parity_of(input logic [DSIZE-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [3:0]             cfg_bw;
  logic [2:0]             cfg_baud;
  logic                   cfg_psel;
  logic                   cfg_pen;
  logic                   rx_en;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   rx_p0;
  logic                   rx_p1;
  logic                   fall;
  state_t                 state;
  state_t                 state_nx;
  logic [11:0]            cnt;
  logic                   tick;
  logic [DSIZE-1:0]       shreg;
  logic [3:0]             bit_idx;
  logic [3:0]             bw_l;
  logic [2:0]             baud_l;
  logic                   psel_l;
  logic                   pen_l;
  logic                   par_pend;
  logic                   last_bit;
  logic                   start_det;
  logic                   shift_en;
  logic                   par_chk;
  logic                   commit;
  logic [5:0]             addr_idx;
  logic                   wr_en;
  logic                   rd_setup;
  logic                   pop;
  logic                   clr_err;
  logic                   valid;
  logic                   parity_err;
  logic                   frame_err;
  logic                   overrun;
  logic                   overrun_ev;
  logic [DSIZE-1:0]       buf_out;
  logic [DSIZE-1:0]       frame_data;
  logic [31:0]            rd_data;
  logic                   unused_bits;

  assign addr_idx    = apb.paddr[7:2];
  assign wr_en       = apb.psel & apb.penable & apb.pwrite;
  assign rd_setup    = apb.psel & ~apb.pwrite & ~apb.penable;
  assign pop         = apb.psel & apb.penable & ~apb.pwrite & (addr_idx == REG_RX_BUFFER);
  assign clr_err     = wr_en & (addr_idx == REG_CONTROL) & apb.pwdata[1];
  assign unused_bits = ^{apb.paddr[31:8], apb.paddr[1:0], apb.pwdata[31:9]};

  // CONFIG and CONTROL register writes.
  always_ff @(posedge pclk) begin
    if (reset) begin
      cfg_bw   <= 4'd8;
      cfg_baud <= 3'd0;
      cfg_psel <= 1'b0;
      cfg_pen  <= 1'b0;
      rx_en    <= 1'b0;
    end else if (wr_en) begin
      if (addr_idx == REG_CONFIG) begin
        cfg_bw   <= apb.pwdata[3:0];
        cfg_baud <= apb.pwdata[6:4];
        cfg_psel <= apb.pwdata[7];
        cfg_pen  <= apb.pwdata[8];
      end
      if (addr_idx == REG_CONTROL) rx_en <= apb.pwdata[0];
    end
  end

  // ---- stage p0: metastability synchronizer, p1: previous line value for edge detect
  always_ff @(posedge pclk) begin
    if (reset) begin
      sync_p <= '1;
      rx_p1  <= 1'b1;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], rxd};
      rx_p1  <= rx_p0;
    end
  end

  assign rx_p0    = sync_p[SYNC_STAGES-1];
  assign fall     = rx_p1 & ~rx_p0;
  assign tick     = (cnt == 12'd0);
  assign last_bit = (bit_idx == (bw_l - 4'd1));

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state; dropping rx_en aborts any frame in progress.
  always_comb begin
    state_nx = state;
    if (!rx_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (fall) state_nx = START;
        START:   if (tick) state_nx = rx_p0 ? IDLE : DATA;
        DATA:    if (tick && last_bit) state_nx = pen_l ? PARITY : STOP;
        PARITY:  if (tick) state_nx = STOP;
        STOP:    if (tick) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM outputs: one-cycle strobes at each mid-bit sample point.
  always_comb begin
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:    start_det = rx_en & fall;
      DATA:    shift_en  = rx_en & tick;
      PARITY:  par_chk   = rx_en & tick;
      STOP:    commit    = rx_en & tick;
      default: ;
    endcase
  end

  // Bit timer, shifter and per-frame config snapshot (reloaded at every start).
  always_ff @(posedge pclk) begin
    if (start_det) begin
      cnt      <= bit_period(cfg_baud) >> 1;
      bit_idx  <= 4'd0;
      shreg    <= '0;
      bw_l     <= eff_width(cfg_bw);
      baud_l   <= cfg_baud;
      psel_l   <= cfg_psel;
      pen_l    <= cfg_pen;
      par_pend <= 1'b0;
    end else begin
      if (tick) cnt <= bit_period(baud_l) - 12'd1;
      else      cnt <= cnt - 12'd1;
      if (shift_en) begin
        shreg   <= {rx_p0, shreg[DSIZE-1:1]};
        bit_idx <= bit_idx + 4'd1;
      end
      if (par_chk && (rx_p0 != parity_of(shreg, psel_l))) par_pend <= 1'b1;
    end
  end

  assign frame_data = align_lsb(shreg, bw_l);

`ifdef UART_RX_FIFO_EN
  logic [DSIZE-1:0] fifo_mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       level;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok     = pop & (level != 3'd0);
  assign overrun_ev = commit & (level == 3'd4) & ~pop_ok;
  assign push_ok    = commit & ~overrun_ev;
  assign valid      = (level != 3'd0);
  assign buf_out    = valid ? fifo_mem[rd_ptr] : '0;

  // FIFO pointers and fill level; a pop frees a slot for a same-cycle push.
  always_ff @(posedge pclk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      level  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
      level <= level + {2'b00, push_ok} - {2'b00, pop_ok};
    end
  end

  // FIFO storage.
  always_ff @(posedge pclk) begin
    if (push_ok) fifo_mem[wr_ptr] <= frame_data;
  end
`else
  logic [DSIZE-1:0] hold;

  assign overrun_ev = commit & valid & ~pop;
  assign buf_out    = hold;

  // Holding-register valid flag; a pop in the commit cycle makes room.
  always_ff @(posedge pclk) begin
    if (reset)                     valid <= 1'b0;
    else if (commit && !overrun_ev) valid <= 1'b1;
    else if (pop)                  valid <= 1'b0;
  end

  // Holding-register data.
  always_ff @(posedge pclk) begin
    if (commit && !overrun_ev) hold <= frame_data;
  end
`endif

  // Sticky error flags; a commit in the clear cycle still records its errors.
  always_ff @(posedge pclk) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr_err) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      if (commit) begin
        if (par_pend)   parity_err <= 1'b1;
        if (!rx_p0)     frame_err  <= 1'b1;
        if (overrun_ev) overrun    <= 1'b1;
      end
    end
  end

  // Interrupt follows the flags one cycle later.
  always_ff @(posedge pclk) begin
    if (reset) rx_irq <= 1'b0;
    else       rx_irq <= valid | parity_err | frame_err | overrun;
  end

  // Read mux; unmapped offsets read zero.
  always_comb begin
    rd_data = '0;
    case (addr_idx)
      REG_CONFIG:    rd_data[8:0] = {cfg_pen, cfg_psel, cfg_baud, cfg_bw};
      REG_CONTROL:   rd_data[0]   = rx_en;
      REG_RX_BUFFER: rd_data[DSIZE-1:0] = buf_out;
      REG_STATUS: begin
        rd_data[4:0] = {(state != IDLE), overrun, frame_err, parity_err, valid};
`ifdef UART_RX_FIFO_EN
        rd_data[7:5] = level;
`endif
      end
      default: ;
    endcase
  end

  // prdata is captured in the setup phase so it is stable for the access phase.
  always_ff @(posedge pclk) begin
    if (reset)         apb.prdata <= '0;
    else if (rd_setup) apb.prdata <= rd_data;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a queue-based model of the receive buffer
// and flags predicts every APB read; directed frames pin the model with
// literal values, then randomized frames exercise widths, bauds and parity.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DSIZE = 8;
  localparam logic [31:0] A_CONFIG  = 32'h00;
  localparam logic [31:0] A_CONTROL = 32'h04;
  localparam logic [31:0] A_RXBUF   = 32'h08;
  localparam logic [31:0] A_STATUS  = 32'h0C;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
  localparam logic [31:0] L1 = 32'h20;
`else
  localparam int CAP = 1;
  localparam logic [31:0] L1 = 32'h00;
`endif

  logic pclk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic rx_irq;

  uart_rx_if apb();

  uart_rx #(.DSIZE(DSIZE), .SYNC_STAGES(2)) dut (
    .pclk  (pclk),
    .reset (reset),
    .apb   (apb.slave),
    .rxd   (rxd),
    .rx_irq(rx_irq)
  );

  always #5 pclk = ~pclk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  m_cfg = 9'h008;
  bit          m_rx_en = 0;
  bit          m_pe = 0;
  bit          m_fe = 0;
  bit          m_ov = 0;
  bit          m_busy = 0;
  int          m_q[$];
  logic [31:0] exp_rd = '0;
  bit          exp_irq = 0;
  string       rd_name = "none";

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endfunction

  function automatic int eff_w(input int w);
    return (w < 5 || w > 8) ? 8 : w;
  endfunction

  function automatic void model_reset();
    m_cfg = 9'h008; m_rx_en = 0; m_pe = 0; m_fe = 0; m_ov = 0; m_busy = 0;
    m_q.delete();
  endfunction

  function automatic bit model_irq();
    return (m_q.size() != 0) | m_pe | m_fe | m_ov;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] r;
    r = '0;
    case (addr[7:2])
      6'd0: r[8:0] = m_cfg;
      6'd1: r[0] = m_rx_en;
      6'd2: if (m_q.size() > 0) r = m_q[0];
      6'd3: begin
        r[0] = (m_q.size() != 0);
        r[1] = m_pe;
        r[2] = m_fe;
        r[3] = m_ov;
        r[4] = m_busy;
`ifdef UART_RX_FIFO_EN
        r[7:5] = 3'(m_q.size());
`endif
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // What a received frame does to the buffer and flags.
  function automatic void model_commit(input int data, input bit par_bit, input bit stop_bit);
    int w;
    int d;
    if (!m_rx_en) return;
    w = eff_w(int'(m_cfg[3:0]));
    d = data & ((1 << w) - 1);
    if (m_cfg[8] && (int'(par_bit) != (($countones(d) & 1) ^ int'(m_cfg[7])))) m_pe = 1;
    if (!stop_bit) m_fe = 1;
    if (m_q.size() >= CAP) m_ov = 1;
    else m_q.push_back(d);
  endfunction

  // Every read access phase is checked against the model.
  always @(negedge pclk) begin
    if (!reset && apb.psel && apb.penable && !apb.pwrite) begin
      check({rd_name, " prdata"}, apb.prdata, exp_rd);
      check({rd_name, " rx_irq"}, {31'd0, rx_irq}, {31'd0, exp_irq});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    tick(1);
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
    apb.paddr = addr; apb.pwdata = data;
    tick(1);
    apb.penable = 1'b1;
    tick(1);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    if (addr[7:2] == 6'd0) m_cfg = data[8:0];
    if (addr[7:2] == 6'd1) begin
      m_rx_en = data[0];
      if (data[1]) begin m_pe = 0; m_fe = 0; m_ov = 0; end
    end
  endtask

  task automatic apb_read(input logic [31:0] addr, input string name, output logic [31:0] data);
    exp_rd = model_read(addr);
    exp_irq = model_irq();
    rd_name = name;
    tick(1);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = addr;
    tick(1);
    apb.penable = 1'b1;
    @(negedge pclk);
    data = apb.prdata;
    tick(1);
    apb.psel = 1'b0; apb.penable = 1'b0;
    if (addr[7:2] == 6'd2 && m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic send_frame(input int data, input bit par_bit, input bit stop_bit);
    int t;
    int w;
    t = 16 << m_cfg[6:4];
    w = eff_w(int'(m_cfg[3:0]));
    rxd = 1'b0; tick(t);
    for (int i = 0; i < w; i++) begin rxd = data[i]; tick(t); end
    if (m_cfg[8]) begin rxd = par_bit; tick(t); end
    rxd = stop_bit; tick(t);
    rxd = 1'b1; tick(2);
    model_commit(data, par_bit, stop_bit);
  endtask

  // Start bit plus nfull data bits, stopping half way into the next bit.
  task automatic send_partial(input int data, input int nfull);
    int t;
    t = 16 << m_cfg[6:4];
    rxd = 1'b0; tick(t);
    for (int i = 0; i < nfull; i++) begin rxd = data[i]; tick(t); end
    rxd = data[nfull]; tick(t / 2);
  endtask

  logic [31:0] rd;

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    model_reset();
    tick(3);
    reset = 1'b0;

    // Reset state
    apb_read(A_CONFIG, "rst_config", rd);   check("rst_config_lit", rd, 32'h008);
    apb_read(A_CONTROL, "rst_control", rd); check("rst_control_lit", rd, 32'h0);
    apb_read(A_STATUS, "rst_status", rd);   check("rst_status_lit", rd, 32'h0);
    check("rst_irq_lit", {31'd0, rx_irq}, 32'h0);

    // 0xA5 8N1 at T=16
    apb_write(A_CONFIG, 32'h008);
    apb_write(A_CONTROL, 32'h1);
    send_frame(8'hA5, 1'b0, 1'b1);
    apb_read(A_STATUS, "a5_status", rd); check("a5_status_lit", rd, 32'h01 | L1);
    apb_read(A_RXBUF, "a5_data", rd);    check("a5_data_lit", rd, 32'hA5);
    apb_read(A_STATUS, "a5_after", rd);  check("a5_after_lit", rd, 32'h00);
    check("a5_irq_lit", {31'd0, rx_irq}, 32'h0);

    // Odd parity, 0x03 sent with a wrong parity bit of 0
    apb_write(A_CONFIG, 32'h188);
    send_frame(8'h03, 1'b0, 1'b1);
    apb_read(A_STATUS, "par_status", rd); check("par_status_lit", rd, 32'h03 | L1);
    apb_read(A_RXBUF, "par_data", rd);    check("par_data_lit", rd, 32'h03);
    apb_read(A_STATUS, "par_sticky", rd); check("par_sticky_lit", rd, 32'h02);
    apb_write(A_CONTROL, 32'h3);
    apb_read(A_STATUS, "par_clear", rd);  check("par_clear_lit", rd, 32'h00);

    // Framing error keeps the data; then a 5-bit frame
    apb_write(A_CONFIG, 32'h008);
    send_frame(8'h55, 1'b0, 1'b0);
    apb_read(A_STATUS, "fe_status", rd); check("fe_status_lit", rd, 32'h05 | L1);
    apb_read(A_RXBUF, "fe_data", rd);    check("fe_data_lit", rd, 32'h55);
    apb_write(A_CONTROL, 32'h3);
    apb_write(A_CONFIG, 32'h005);
    send_frame(8'h1F, 1'b0, 1'b1);
    apb_read(A_RXBUF, "w5_data", rd);    check("w5_data_lit", rd, 32'h1F);

    // Two frames with no read in between
    apb_write(A_CONFIG, 32'h008);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
`ifdef UART_RX_FIFO_EN
    apb_read(A_STATUS, "two_status", rd); check("two_status_lit", rd, 32'h41);
    apb_read(A_RXBUF, "two_first", rd);   check("two_first_lit", rd, 32'h11);
    apb_read(A_STATUS, "two_mid", rd);    check("two_mid_lit", rd, 32'h21);
    apb_read(A_RXBUF, "two_second", rd);  check("two_second_lit", rd, 32'h22);
    apb_read(A_STATUS, "two_empty", rd);  check("two_empty_lit", rd, 32'h00);
    apb_read(A_RXBUF, "empty_read", rd);  check("empty_read_lit", rd, 32'h00);
`else
    apb_read(A_STATUS, "ovr_status", rd); check("ovr_status_lit", rd, 32'h09);
    apb_read(A_RXBUF, "ovr_data", rd);    check("ovr_data_lit", rd, 32'h11);
    apb_read(A_STATUS, "ovr_after", rd);  check("ovr_after_lit", rd, 32'h08);
    apb_write(A_CONTROL, 32'h3);
`endif

    // 5-cycle glitch: busy while the start bit is being qualified, then nothing
    fork
      begin rxd = 1'b0; tick(5); rxd = 1'b1; end
      begin tick(3); m_busy = 1; apb_read(A_STATUS, "glitch_busy", rd); m_busy = 0; end
    join
    check("glitch_busy_lit", rd, 32'h10);
    tick(20);
    apb_read(A_STATUS, "glitch_after", rd); check("glitch_after_lit", rd, 32'h00);

    // rx_en cleared during data bit 3
    send_partial(8'h7E, 3);
    apb_write(A_CONTROL, 32'h0);
    rxd = 1'b1;
    apb_read(A_STATUS, "abort_en", rd); check("abort_en_lit", rd, 32'h00);
    apb_write(A_CONTROL, 32'h1);
    tick(5);
    send_frame(8'h7E, 1'b0, 1'b1);
    apb_read(A_RXBUF, "after_abort", rd); check("after_abort_lit", rd, 32'h7E);

    // reset during data bit 3
    send_partial(8'h7E, 3);
    reset = 1'b1; rxd = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
    apb_read(A_STATUS, "abort_rst", rd);   check("abort_rst_lit", rd, 32'h00);
    apb_read(A_CONFIG, "rst_cfg2", rd);    check("rst_cfg2_lit", rd, 32'h008);
    apb_write(A_CONTROL, 32'h1);
    send_frame(8'h7E, 1'b0, 1'b1);
    apb_read(A_RXBUF, "after_rst", rd);    check("after_rst_lit", rd, 32'h7E);

    // Randomized frames against the model
    for (int it = 0; it < 30; it++) begin
      int bw;
      int baud;
      int data;
      int d;
      bit cps;
      bit cpe;
      bit par;
      bit stp;
      bw   = $urandom_range(0, 15);
      baud = $urandom_range(0, 2);
      cps  = 1'($urandom_range(0, 1));
      cpe  = 1'($urandom_range(0, 1));
      data = $urandom_range(0, 255);
      apb_write(A_CONFIG, {23'd0, cpe, cps, baud[2:0], bw[3:0]});
      d   = data & ((1 << eff_w(bw)) - 1);
      par = 1'(($countones(d) & 1) ^ int'(cps));
      stp = 1'b1;
      if (m_q.size() < CAP) begin
        if ($urandom_range(0, 3) == 0) par = ~par;
        if ($urandom_range(0, 5) == 0) stp = 1'b0;
      end
      send_frame(data, par, stp);
      case ($urandom_range(0, 3))
        0, 1: begin
          apb_read(A_STATUS, "rnd_status", rd);
          if (m_q.size() > 0) apb_read(A_RXBUF, "rnd_data", rd);
        end
        2: begin
          apb_write(A_CONTROL, 32'h3);
          apb_read(A_STATUS, "rnd_clear", rd);
        end
        default: apb_read(A_STATUS, "rnd_peek", rd);
      endcase
    end

    while (m_q.size() > 0) apb_read(A_RXBUF, "drain", rd);
    apb_read(A_STATUS, "final_status", rd);
    apb_read(32'h40, "unmapped", rd); check("unmapped_lit", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
